// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: FSM states,
// forwarding-mux select encoding and the sequencing counter width.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    LSTALL = 3'd1,
    BFLUSH = 3'd2,
    HALT   = 3'd3,
    STEP   = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EM  = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // One counter serves both load stalls and branch flushes; two bits hold
  // LOAD_LAT up to 3 and FLUSH_CYC up to 4, and match the stall_cnt port.
  localparam int CNT_W = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Execute-stage operand forwarding select for one ALU source operand.
// Purely combinational; Execute/Memory has priority over Writeback.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] em_rd_i,
  input  logic              em_wre_i,
  input  logic              em_load_i,
  input  logic [REG_AW-1:0] mw_rd_i,
  input  logic              mw_wre_i,
  output logic [1:0]        sel_o
);

  fwd_sel_t sel;

  // Load data is not ready in Memory; the load-use stall makes the
  // consumer pick it up from Writeback instead.
  always_comb begin
    sel = FWD_REG;
    if (em_wre_i && !em_load_i && (em_rd_i == src_i)) begin
      sel = FWD_EM;
    end else if (mw_wre_i && (mw_rd_i == src_i)) begin
      sel = FWD_WB;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and debug sequencing controller for the 5-stage pipeline: PC and
// pipeline-register enables/flushes, load-use stalls, branch flushes, halt/step.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] fd_rs1,
  input  logic [REG_AW-1:0] fd_rs2,
  input  logic              fd_use1,
  input  logic              fd_use2,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_wre,
  input  logic              de_load,
  input  logic [REG_AW-1:0] em_rd,
  input  logic              em_wre,
  input  logic              em_load,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic              mw_wre,
  input  logic              branch_taken,
  input  logic              halt_req,
  input  logic              step_req,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [1:0]        stall_cnt
);

  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYC - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_haz;
  logic hazard_state;
  logic branch_go;
  logic load_go;
  logic pc_en_c, fd_en_c, fd_flush_c, de_flush_c;

  assign load_haz = de_load && de_wre &&
                    ((fd_use1 && (fd_rs1 == de_rd)) || (fd_use2 && (fd_rs2 == de_rd)));

  // A step cycle behaves as RUN, so hazards there preempt the return to HALT.
  assign hazard_state = (state_q == RUN) || (state_q == STEP);
  assign branch_go    = branch_taken && (hazard_state || (state_q == LSTALL));
  assign load_go      = load_haz && !branch_taken && hazard_state;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en_c    = 1'b1;
    fd_en_c    = 1'b1;
    fd_flush_c = 1'b0;
    de_flush_c = 1'b0;
    if (branch_go) begin
      fd_flush_c = 1'b1;
      de_flush_c = 1'b1;
      state_d    = (FLUSH_CYC > 1) ? BFLUSH : RUN;
      cnt_d      = (FLUSH_CYC > 1) ? FLUSH_CNT : '0;
    end else if (load_go) begin
      pc_en_c    = 1'b0;
      fd_en_c    = 1'b0;
      de_flush_c = 1'b1;
      state_d    = (LOAD_LAT > 0) ? LSTALL : RUN;
      cnt_d      = LOAD_CNT;
    end else begin
      case (state_q)
        RUN, STEP: begin
          state_d = halt_req ? HALT : RUN;
        end
        LSTALL: begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          de_flush_c = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        BFLUSH: begin
          fd_flush_c = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HALT: begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          de_flush_c = 1'b1;
          if (step_req) begin
            state_d = STEP;
          end else if (!halt_req) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held the pipeline sees plain RUN controls regardless of inputs.
  assign pc_en     = pc_en_c | ~reset;
  assign fd_en     = fd_en_c | ~reset;
  assign fd_flush  = fd_flush_c & reset;
  assign de_flush  = de_flush_c & reset;
  assign halted    = (state_q == HALT);
  assign stall_cnt = (state_q == LSTALL) ? cnt_q : '0;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i     (de_rs1),
    .em_rd_i   (em_rd),
    .em_wre_i  (em_wre),
    .em_load_i (em_load),
    .mw_rd_i   (mw_rd),
    .mw_wre_i  (mw_wre),
    .sel_o     (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i     (de_rs2),
    .em_rd_i   (em_rd),
    .em_wre_i  (em_wre),
    .em_load_i (em_load),
    .mw_rd_i   (mw_rd),
    .mw_wre_i  (mw_wre),
    .sel_o     (fwd_b)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 16-bit, 5-stage (Fetch/Decode/Execute/Memory/Writeback) pipeline.
- Generates PC and pipeline-register enables and flushes, plus execute-stage operand forwarding selects.
- Inserts load-use stalls to cover the synchronous data-RAM read, and flushes wrong-path instructions after a taken branch.
- Provides halt/single-step sequencing for debug.
- Sits beside the datapath; drives the PC register, Fetch/Decode and Decode/Execute pipeline registers, and the two forwarding muxes feeding the ALU.

Parameters:
REG_AW, 4, register-address width
LOAD_LAT, 1, data-RAM read latency in cycles; load-use stall length is LOAD_LAT+1
FLUSH_CYC, 2, cycles Fetch/Decode is flushed after a taken branch (covers synchronous ROM latency)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
fd_rs1  in  REG_AW  source register 1 of instruction in Decode
fd_rs2  in  REG_AW  source register 2 of instruction in Decode
fd_use1  in  1  Decode instruction reads rs1
fd_use2  in  1  Decode instruction reads rs2
de_rs1  in  REG_AW  srcA register of instruction in Execute
de_rs2  in  REG_AW  srcB register of instruction in Execute
de_rd  in  REG_AW  destination register in Execute
de_wre  in  1  Execute instruction writes the register file
de_load  in  1  Execute instruction is a RAM load
em_rd  in  REG_AW  destination register in Memory
em_wre  in  1  Memory instruction writes the register file
em_load  in  1  Memory instruction is a RAM load
mw_rd  in  REG_AW  destination register in Writeback
mw_wre  in  1  Writeback instruction writes the register file
branch_taken  in  1  Execute resolved a taken branch (next-PC select)
halt_req  in  1  debug halt request (level)
step_req  in  1  debug single-step pulse, honoured only while halted
pc_en  out  1  PC register load enable
fd_en  out  1  Fetch/Decode register enable
fd_flush  out  1  Fetch/Decode register clear (inserts NOP)
de_flush  out  1  Decode/Execute register clear (inserts bubble)
fwd_a  out  2  srcA select: 00 Decode/Execute value, 01 Execute/Memory result, 10 Writeback data
fwd_b  out  2  srcB select, same encoding as fwd_a
halted  out  1  controller is in HALT
stall_cnt  out  2  remaining load-stall cycles (debug visibility)

Behaviour:
- Reset (reset low, asynchronous): state=RUN, counters=0, halted=0. Pipeline-control outputs take their RUN values: pc_en=1, fd_en=1, fd_flush=0, de_flush=0. fwd_a/fwd_b remain combinational from the current inputs.
- FSM states: RUN, LSTALL, BFLUSH, HALT, STEP.
- Hazard definitions:
  - Load hazard: de_load and de_wre and ((fd_use1 and fd_rs1==de_rd) or (fd_use2 and fd_rs2==de_rd)).
  - Branch: branch_taken.
- RUN:
  - All enables 1, no flushes.
  - Branch: drive fd_flush=1 and de_flush=1 in the same cycle; next state BFLUSH with counter=FLUSH_CYC-1. If FLUSH_CYC=1, next state is RUN.
  - Load hazard (and no branch): pc_en=0, fd_en=0, de_flush=1; next state LSTALL with counter=LOAD_LAT.
  - halt_req (and neither hazard): next state HALT.
- LSTALL:
  - pc_en=0, fd_en=0, de_flush=1.
  - Counter decrements each cycle; at 0, next state is RUN.
  - A branch during LSTALL preempts it: same action as the branch case in RUN.
- BFLUSH: fd_flush=1, pc_en=1. Counter decrements; at 0, next state is RUN.
- HALT:
  - pc_en=0, fd_en=0, de_flush=1; halted=1.
  - step_req: next state STEP.
  - halt_req low: next state RUN.
- STEP:
  - Exactly one cycle with RUN outputs.
  - Next state is HALT if halt_req is still high, otherwise RUN.
  - A hazard detected in STEP is handled exactly as in RUN (stall/flush takes priority over returning to HALT).
- Priority within a cycle: branch > load hazard > halt/step.
- Forwarding (combinational, all states):
  - fwd_a=01 when em_wre and !em_load and em_rd==de_rs1.
  - Else fwd_a=10 when mw_wre and mw_rd==de_rs1.
  - Else fwd_a=00.
  - fwd_b uses the same rule with de_rs2.
  - Execute/Memory beats Writeback when both match.
  - A load in Memory is never forwarded; the load-use stall guarantees the consumer sees it from Writeback.
- Register 0 gets no special treatment.
- reset asserted mid-stall or mid-flush: immediate return to RUN; counters cleared.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum ctrl_state_t {RUN, LSTALL, BFLUSH, HALT, STEP}
  - fwd_sel_t encoding: FWD_REG=2'b00, FWD_EM=2'b01, FWD_WB=2'b10
- Sub-module fwd_unit: purely combinational forwarding compare; instantiated once per operand, twice in total.

Test Plan:
- Reset released, no hazards → pc_en=1, fd_en=1, fwd_a=fwd_b=00, halted=0.
- em_rd=3, em_wre=1, mw_rd=3, mw_wre=1, de_rs1=3, de_rs2=5 → fwd_a=01, fwd_b=00. Then em_load=1 → fwd_a=10.
- Load de_rd=4 with fd_rs2=4, fd_use2=1, LOAD_LAT=1 → pc_en=0, fd_en=0, de_flush=1 for exactly 2 cycles, then RUN.
- branch_taken=1 for 1 cycle, FLUSH_CYC=2 → fd_flush=1 for 2 consecutive cycles, de_flush=1 in the first cycle only.
- Load hazard and branch_taken in the same cycle → branch flush wins, no stall. Branch arriving on the second LSTALL cycle → immediate flush.
- halt_req=1 → halted=1 with pc_en=0. step_req pulse → exactly one cycle with pc_en=1, then halted=1 again. reset low during HALT → RUN immediately.
